// File: rtl/mul4_c_pkg.sv
// Shared types and sizing helpers for the mul4_c iterative multiplier.
package mul4_c_pkg;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DONE
  } state_e;

  localparam int unsigned WIDTH_DEF = 4;

  function automatic int unsigned cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul4_c_step.sv
// One shift-add step: conditionally adds a_r shifted by count into the accumulator.
module mul4_c_step
  import mul4_c_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CW    = cnt_w(WIDTH)
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   a_r,
  input  logic               bit_i,
  input  logic [CW-1:0]      count,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [2*WIDTH-1:0] partial;

  always_comb begin
    partial = (2*WIDTH)'(a_r) << count;
    acc_out = bit_i ? (acc_in + partial) : acc_in;
  end

endmodule

// File: rtl/mul4_c.sv
// Free-running iterative unsigned multiplier (LOAD -> RUN x WIDTH -> DONE).
// Optional `done` pulse port enabled by defining MUL4_C_DONE_EN.
module mul4_c
  import mul4_c_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] z
`ifdef MUL4_C_DONE_EN
  ,
  output logic               done
`endif
);

  localparam int unsigned CW = cnt_w(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   a_r_q;
  logic [WIDTH-1:0]   b_r_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] z_q;
`ifdef MUL4_C_DONE_EN
  logic               done_q;
`endif

  mul4_c_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .acc_in  (acc_q),
    .a_r     (a_r_q),
    .bit_i   (b_r_q[count_q]),
    .count   (count_q),
    .acc_out (acc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      a_r_q   <= '0;
      b_r_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      z_q     <= '0;
`ifdef MUL4_C_DONE_EN
      done_q  <= 1'b0;
`endif
    end else begin
`ifdef MUL4_C_DONE_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        LOAD: begin
          a_r_q   <= a;
          b_r_q   <= b;
          acc_q   <= '0;
          count_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          // Operand change aborts the iteration so no stale partial can reach z.
          if ((a != a_r_q) || (b != b_r_q)) begin
            state_q <= LOAD;
          end else begin
            acc_q <= acc_d;
            if (count_q == CW'(WIDTH - 1)) begin
              state_q <= DONE;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        DONE: begin
          z_q     <= acc_q;
`ifdef MUL4_C_DONE_EN
          done_q  <= 1'b1;
`endif
          state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign z = z_q;
`ifdef MUL4_C_DONE_EN
  assign done = done_q;
`endif

endmodule

// File: tb/tb_mul4_c.sv
// Self-checking bench for mul4_c: directed latency/restart/reset steps plus random operand windows.
module tb_mul4_c;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a     = '0;
  logic [3:0] b     = '0;
  logic [7:0] z;
`ifdef MUL4_C_DONE_EN
  logic       done;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul4_c #(
    .WIDTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .z     (z)
`ifdef MUL4_C_DONE_EN
    ,
    .done  (done)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] prod(input logic [3:0] x, input logic [3:0] y);
    int unsigned p;
    p = int'(x) * int'(y);
    return p[7:0];
  endfunction

  logic [3:0] dir_a [7] = '{4'd2, 4'd3, 4'd3, 4'd5, 4'd7, 4'd15, 4'd0};
  logic [3:0] dir_b [7] = '{4'd2, 4'd2, 4'd6, 4'd2, 4'd1, 4'd15, 4'd9};

  initial begin
    logic [7:0] prev;
    logic [7:0] exp;
    logic [3:0] na;
    logic [3:0] nb;
    int         pulses;

    #1;
    chk("reset_z", z, 8'h00);
`ifdef MUL4_C_DONE_EN
    chk("reset_done", {7'b0, done}, 8'h00);
`endif

    // First product appears exactly 6 edges after reset release.
    a = 4'd3;
    b = 4'd6;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("latency_before_done", z, 8'h00);
    @(negedge clk);
    chk("latency_first_product", z, 8'h12);

    // Change b while RUN is at count 1: abort, z holds 18 until the restarted DONE.
    repeat (2) @(negedge clk);
    b = 4'd2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("restart_hold_old", z, 8'h12);
`ifdef MUL4_C_DONE_EN
      chk("restart_no_done", {7'b0, done}, 8'h00);
`endif
    end
    @(negedge clk);
    chk("restart_new_product", z, 8'h06);
`ifdef MUL4_C_DONE_EN
    chk("restart_done_pulse", {7'b0, done}, 8'h01);
`endif

    // Directed table then random pairs, each held 10 cycles.
    prev = 8'h06;
    for (int i = 0; i < 23; i++) begin
      if (i < 7) begin
        na = dir_a[i];
        nb = dir_b[i];
      end else begin
        na = 4'($urandom_range(15, 0));
        nb = 4'($urandom_range(15, 0));
      end
      a   = na;
      b   = nb;
      exp = prod(na, nb);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (c < 9) chk("no_glitch", {7'b0, (z === prev) || (z === exp)}, 8'h01);
      end
      chk($sformatf("product_%0d_x_%0d", na, nb), z, exp);
`ifdef MUL4_C_DONE_EN
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done === 1'b1) begin
          pulses++;
          chk("done_with_z", z, exp);
        end
      end
      chk("done_pulse_count", 8'(pulses), 8'd2);
`endif
      prev = exp;
    end

    // Async reset mid-iteration clears z without a clock edge.
    a = 4'd9;
    b = 4'd13;
    repeat (10) @(negedge clk);
    chk("pre_reset_product", z, 8'h75);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_z", z, 8'h00);
    @(negedge clk);
    chk("reset_held_z", z, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_before_done", z, 8'h00);
    @(negedge clk);
    chk("post_reset_product", z, 8'h75);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
